// File: rtl/stage_wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings and FSM state type.
package stage_wb_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE,
      WAIT_MEM
   } wb_state_t;

endpackage

// File: rtl/stage_wb_load_align.sv
// Combinational load data alignment: extracts byte/half/word from a memory word
// and flags misaligned halfword/word accesses.
module load_align
   import stage_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{addr_lo, 3'b000} +: 8];
   assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

   // Any encoding that is not a byte or halfword load behaves as LW.
   always_comb begin
      data       = word;
      misaligned = 1'b0;
      case (funct3)
         F3_LB: begin
            data = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_LBU: begin
            data = {24'd0, byte_sel};
         end
         F3_LH: begin
            data       = {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         F3_LHU: begin
            data       = {16'd0, half_sel};
            misaligned = addr_lo[0];
         end
         default: begin
            data       = word;
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: retires non-load results directly and waits on data memory for loads.
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
module stage_wb
   import stage_wb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [4:0]  rd_i,
   input  logic [31:0] result_i,
   input  logic        is_ld_mem_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] dmem_dat_i,
   input  logic        dmem_ack_i,
   input  logic        dmem_err_i,
   output logic        rf_we_o,
   output logic [4:0]  rd_o,
   output logic [31:0] rf_wd_o,
   output logic        retire_o,
   output logic        e_load_fault_o,
   output logic        e_misaligned_o
`ifdef WB_FWD_EN
   ,
   output logic        fwd_valid_o,
   output logic [4:0]  fwd_rd_o,
   output logic [31:0] fwd_dat_o
`endif
);

   wb_state_t   state;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;

   logic [2:0]  align_funct3;
   logic [1:0]  align_addr_lo;
   logic [31:0] align_data;
   logic        align_misaligned;

   assign ready_o = (state == IDLE);

   // One aligner serves both phases: in IDLE it judges the incoming load's
   // alignment, in WAIT_MEM it shapes the returned word using captured fields.
   assign align_funct3  = (state == IDLE) ? funct3_i  : ld_funct3;
   assign align_addr_lo = (state == IDLE) ? addr_lo_i : ld_addr_lo;

   load_align u_load_align (
      .word       (dmem_dat_i),
      .funct3     (align_funct3),
      .addr_lo    (align_addr_lo),
      .data       (align_data),
      .misaligned (align_misaligned)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         ld_rd          <= 5'd0;
         ld_funct3      <= 3'd0;
         ld_addr_lo     <= 2'd0;
         rf_we_o        <= 1'b0;
         rd_o           <= 5'd0;
         rf_wd_o        <= 32'd0;
         retire_o       <= 1'b0;
         e_load_fault_o <= 1'b0;
         e_misaligned_o <= 1'b0;
      end else begin
         rf_we_o        <= 1'b0;
         retire_o       <= 1'b0;
         e_load_fault_o <= 1'b0;
         e_misaligned_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  if (!is_ld_mem_i) begin
                     rf_we_o  <= (rd_i != 5'd0);
                     rd_o     <= rd_i;
                     rf_wd_o  <= result_i;
                     retire_o <= 1'b1;
                  end else if (align_misaligned) begin
                     e_misaligned_o <= 1'b1;
                     retire_o       <= 1'b1;
                  end else begin
                     ld_rd      <= rd_i;
                     ld_funct3  <= funct3_i;
                     ld_addr_lo <= addr_lo_i;
                     state      <= WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (dmem_err_i) begin
                  e_load_fault_o <= 1'b1;
                  retire_o       <= 1'b1;
                  state          <= IDLE;
               end else if (dmem_ack_i) begin
                  rf_we_o  <= (ld_rd != 5'd0);
                  rd_o     <= ld_rd;
                  rf_wd_o  <= align_data;
                  retire_o <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_FWD_EN
   assign fwd_valid_o = rf_we_o;
   assign fwd_rd_o    = rd_o;
   assign fwd_dat_o   = rf_wd_o;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Testbench for stage_wb: table of transactions with expected writeback results,
// checked through a scoreboard queue, plus hand-written reset and stall sequences.
module tb_stage_wb;

   typedef struct {
      logic        is_ld;
      logic [4:0]  rd;
      logic [31:0] result;
      logic [2:0]  funct3;
      logic [1:0]  addr_lo;
      logic [31:0] word;
      int          wait_cycles;
      logic        ack;
      logic        err;
      logic        exp_we;
      logic [31:0] exp_wd;
      logic        exp_fault;
      logic        exp_mis;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        fault;
      logic        mis;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [4:0]  rd_i;
   logic [31:0] result_i;
   logic        is_ld_mem_i;
   logic [2:0]  funct3_i;
   logic [1:0]  addr_lo_i;
   logic [31:0] dmem_dat_i;
   logic        dmem_ack_i;
   logic        dmem_err_i;
   logic        rf_we_o;
   logic [4:0]  rd_o;
   logic [31:0] rf_wd_o;
   logic        retire_o;
   logic        e_load_fault_o;
   logic        e_misaligned_o;
`ifdef WB_FWD_EN
   logic        fwd_valid_o;
   logic [4:0]  fwd_rd_o;
   logic [31:0] fwd_dat_o;
`endif

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk_i = ~clk_i;

   stage_wb dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .rd_i           (rd_i),
      .result_i       (result_i),
      .is_ld_mem_i    (is_ld_mem_i),
      .funct3_i       (funct3_i),
      .addr_lo_i      (addr_lo_i),
      .dmem_dat_i     (dmem_dat_i),
      .dmem_ack_i     (dmem_ack_i),
      .dmem_err_i     (dmem_err_i),
      .rf_we_o        (rf_we_o),
      .rd_o           (rd_o),
      .rf_wd_o        (rf_wd_o),
      .retire_o       (retire_o),
      .e_load_fault_o (e_load_fault_o),
      .e_misaligned_o (e_misaligned_o)
`ifdef WB_FWD_EN
      ,
      .fwd_valid_o    (fwd_valid_o),
      .fwd_rd_o       (fwd_rd_o),
      .fwd_dat_o      (fwd_dat_o)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic is_ld, input logic [4:0] rd, input logic [31:0] result,
                               input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word,
                               input int waits, input logic ack, input logic err,
                               input logic exp_we, input logic [31:0] exp_wd,
                               input logic exp_fault, input logic exp_mis);
      vec_t v;
      v.is_ld = is_ld; v.rd = rd; v.result = result; v.funct3 = f3; v.addr_lo = lo;
      v.word = word; v.wait_cycles = waits; v.ack = ack; v.err = err;
      v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_fault = exp_fault; v.exp_mis = exp_mis;
      return v;
   endfunction

   // Every writeback-side pulse must match the oldest outstanding expectation.
   always @(negedge clk_i) begin
      if (!rst_i && (retire_o || rf_we_o || e_load_fault_o || e_misaligned_o)) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_output: retire=%0b we=%0b fault=%0b mis=%0b, expected none",
                     retire_o, rf_we_o, e_load_fault_o, e_misaligned_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("retire", {31'd0, retire_o}, 32'd1);
            checkOutput("rf_we", {31'd0, rf_we_o}, {31'd0, e.we});
            checkOutput("load_fault", {31'd0, e_load_fault_o}, {31'd0, e.fault});
            checkOutput("misaligned", {31'd0, e_misaligned_o}, {31'd0, e.mis});
            if (e.we) begin
               checkOutput("rd", {27'd0, rd_o}, {27'd0, e.rd});
               checkOutput("rf_wd", rf_wd_o, e.wd);
            end
`ifdef WB_FWD_EN
            checkOutput("fwd_valid", {31'd0, fwd_valid_o}, {31'd0, e.we});
`endif
         end
      end
   end

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      valid_i     = 1'b1;
      is_ld_mem_i = v.is_ld;
      rd_i        = v.rd;
      result_i    = v.result;
      funct3_i    = v.funct3;
      addr_lo_i   = v.addr_lo;
      e.we = v.exp_we; e.rd = v.rd; e.wd = v.exp_wd; e.fault = v.exp_fault; e.mis = v.exp_mis;
      sb.push_back(e);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      if (v.is_ld && !v.exp_mis) begin
         dmem_dat_i = v.word;
         repeat (v.wait_cycles) begin
            checkOutput("ready_wait", {31'd0, ready_o}, 32'd0);
            @(posedge clk_i); #1;
         end
         checkOutput("ready_wait", {31'd0, ready_o}, 32'd0);
         dmem_ack_i = v.ack;
         dmem_err_i = v.err;
         @(posedge clk_i); #1;
         dmem_ack_i = 1'b0;
         dmem_err_i = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; rd_i = '0; result_i = '0; is_ld_mem_i = 1'b0;
      funct3_i = '0; addr_lo_i = '0; dmem_dat_i = '0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;

      //          ld  rd     result        f3      lo     word          w  ack err we  exp_wd        flt mis
      vecs.push_back(mk(0, 5'd5,  32'h0000_1234, 3'b000, 2'd0, 32'h0,         0, 0, 0, 1, 32'h0000_1234, 0, 0));
      vecs.push_back(mk(1, 5'd7,  32'h0,         3'b000, 2'd3, 32'h80FF_0000, 2, 1, 0, 1, 32'hFFFF_FF80, 0, 0));
      vecs.push_back(mk(1, 5'd8,  32'h0,         3'b101, 2'd2, 32'hBEEF_0001, 0, 1, 0, 1, 32'h0000_BEEF, 0, 0));
      vecs.push_back(mk(1, 5'd9,  32'h0,         3'b001, 2'd2, 32'hBEEF_0001, 1, 1, 0, 1, 32'hFFFF_BEEF, 0, 0));
      vecs.push_back(mk(1, 5'd11, 32'h0,         3'b010, 2'd1, 32'h0,         0, 0, 0, 0, 32'h0,         0, 1));
      vecs.push_back(mk(1, 5'd10, 32'h0,         3'b010, 2'd0, 32'h1234_5678, 1, 1, 1, 0, 32'h0,         1, 0));
      vecs.push_back(mk(0, 5'd0,  32'hDEAD_BEEF, 3'b000, 2'd0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 5'd3,  32'h0,         3'b100, 2'd1, 32'h1234_5678, 0, 1, 0, 1, 32'h0000_0056, 0, 0));
      vecs.push_back(mk(1, 5'd4,  32'h0,         3'b001, 2'd0, 32'h0000_8001, 3, 1, 0, 1, 32'hFFFF_8001, 0, 0));
      vecs.push_back(mk(1, 5'd31, 32'h0,         3'b111, 2'd0, 32'hCAFE_BABE, 0, 1, 0, 1, 32'hCAFE_BABE, 0, 0));
      vecs.push_back(mk(1, 5'd12, 32'h0,         3'b001, 2'd1, 32'h0,         0, 0, 0, 0, 32'h0,         0, 1));
      vecs.push_back(mk(1, 5'd13, 32'h0,         3'b101, 2'd3, 32'h0,         0, 0, 0, 0, 32'h0,         0, 1));
      vecs.push_back(mk(1, 5'd0,  32'h0,         3'b000, 2'd2, 32'h00AA_0000, 0, 1, 0, 0, 32'h0,         0, 0));
      vecs.push_back(mk(1, 5'd14, 32'h0,         3'b011, 2'd2, 32'h0,         0, 0, 0, 0, 32'h0,         0, 1));
      vecs.push_back(mk(1, 5'd15, 32'h0,         3'b010, 2'd0, 32'h0,         3, 0, 1, 0, 32'h0,         1, 0));
      vecs.push_back(mk(0, 5'd20, 32'hA5A5_5A5A, 3'b000, 2'd0, 32'h0,         0, 0, 0, 1, 32'hA5A5_5A5A, 0, 0));
      vecs.push_back(mk(1, 5'd21, 32'h0,         3'b100, 2'd3, 32'hF123_4567, 0, 1, 0, 1, 32'h0000_00F1, 0, 0));

      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      checkOutput("reset_ready", {31'd0, ready_o}, 32'd1);
      checkOutput("reset_we", {31'd0, rf_we_o}, 32'd0);
      checkOutput("reset_rd", {27'd0, rd_o}, 32'd0);
      checkOutput("reset_wd", rf_wd_o, 32'd0);

      foreach (vecs[i]) applyStimulus(vecs[i]);
      @(posedge clk_i); #1;
      checkOutput("hold_rd", {27'd0, rd_o}, 32'd21);
      checkOutput("hold_wd", rf_wd_o, 32'h0000_00F1);

      // valid_i presented during a memory wait must be ignored.
      valid_i = 1'b1; is_ld_mem_i = 1'b1; rd_i = 5'd17; funct3_i = 3'b010; addr_lo_i = 2'd0;
      begin
         exp_t e;
         e.we = 1'b1; e.rd = 5'd17; e.wd = 32'h1111_2222; e.fault = 1'b0; e.mis = 1'b0;
         sb.push_back(e);
      end
      @(posedge clk_i); #1;
      is_ld_mem_i = 1'b0; rd_i = 5'd6; result_i = 32'h0000_0666;
      repeat (2) begin
         checkOutput("stall_ready", {31'd0, ready_o}, 32'd0);
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; dmem_dat_i = 32'h1111_2222; dmem_ack_i = 1'b1;
      @(posedge clk_i); #1;
      dmem_ack_i = 1'b0;
      @(posedge clk_i); #1;

      // Reset while waiting on memory abandons the load, even with ack in that cycle.
      valid_i = 1'b1; is_ld_mem_i = 1'b1; rd_i = 5'd18; funct3_i = 3'b010; addr_lo_i = 2'd0;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      checkOutput("pre_reset_ready", {31'd0, ready_o}, 32'd0);
      rst_i = 1'b1; dmem_ack_i = 1'b1; dmem_dat_i = 32'h7777_8888;
      @(posedge clk_i); #1;
      rst_i = 1'b0; dmem_ack_i = 1'b0;
      checkOutput("rst_wait_ready", {31'd0, ready_o}, 32'd1);
      checkOutput("rst_wait_we", {31'd0, rf_we_o}, 32'd0);
      checkOutput("rst_wait_retire", {31'd0, retire_o}, 32'd0);
      checkOutput("rst_wait_rd", {27'd0, rd_o}, 32'd0);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_after_retire", {31'd0, retire_o}, 32'd0);
      checkOutput("sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
